ternary_trit_loader: RTL

//   Upstream stimulus stage for the combinational ternary arity cores.

---
 rtl/ternary_trit_loader.sv | 109 ++++++++++
 1 files changed

// File: rtl/ternary_trit_loader.sv
// ternary_trit_loader: assembles serial trits into a core input word, holds it for a settle
// time, then captures the core output as a registered result with a one-cycle strobe.
module ternary_trit_loader #(
    parameter int NUM_TRITS     = 3,
    parameter int SETTLE_CYCLES = 4,
    parameter int OUT_TRITS     = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [1:0]             trit_in,
    input  logic                   trit_valid,
    output logic                   trit_ready,
    input  logic                   err_clr,
    output logic [2*NUM_TRITS-1:0] word_out,
    output logic                   word_valid,
    input  logic [2*OUT_TRITS-1:0] result_in,
    output logic [2*OUT_TRITS-1:0] result_out,
    output logic                   result_valid,
    output logic                   err_illegal
);
    typedef enum logic {LOAD, SETTLE} state_t;
    localparam int WW = 2 * NUM_TRITS;
    localparam int RW = 2 * OUT_TRITS;
    localparam int CW = NUM_TRITS > 1 ? $clog2(NUM_TRITS) : 1;
    localparam int SW = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [WW-1:0] WZERO = {NUM_TRITS{2'b01}};
    localparam logic [RW-1:0] RZERO = {OUT_TRITS{2'b01}};

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [SW-1:0] settle_q, settle_d;
    logic [WW-1:0] shift_q, shift_d, word_q, word_d, shift_nx;
    logic [RW-1:0] res_q, res_d;
    logic          word_valid_q, word_valid_d, res_valid_q, res_valid_d, err_q, err_d;
    logic          accept, illegal, last;

    assign trit_ready = state_q == LOAD;
    assign accept     = trit_valid & trit_ready;
    assign illegal    = trit_in == 2'b00;
    assign shift_nx   = WW'({shift_q, trit_in});
    assign last       = cnt_q == CW'(NUM_TRITS - 1);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        settle_d     = settle_q;
        shift_d      = shift_q;
        word_d       = word_q;
        res_d        = res_q;
        word_valid_d = 1'b0;
        res_valid_d  = 1'b0;
        err_d        = err_q & ~err_clr;
        if (state_q == LOAD) begin
            if (accept && illegal) begin
                // an illegal trit throws away the partial word; set beats err_clr
                cnt_d   = '0;
                shift_d = WZERO;
                err_d   = 1'b1;
            end else if (accept) begin
                shift_d = shift_nx;
                cnt_d   = last ? '0 : cnt_q + CW'(1);
                if (last) begin
                    word_d       = shift_nx;
                    word_valid_d = 1'b1;
                    state_d      = SETTLE;
                    settle_d     = SW'(SETTLE_CYCLES - 1);
                end
            end
        end else begin
            settle_d = settle_q - SW'(1);
            if (settle_q == '0) begin
                res_d       = result_in;
                res_valid_d = 1'b1;
                state_d     = LOAD;
                settle_d    = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= LOAD;
            cnt_q        <= '0;
            settle_q     <= '0;
            shift_q      <= WZERO;
            word_q       <= WZERO;
            res_q        <= RZERO;
            word_valid_q <= 1'b0;
            res_valid_q  <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            settle_q     <= settle_d;
            shift_q      <= shift_d;
            word_q       <= word_d;
            res_q        <= res_d;
            word_valid_q <= word_valid_d;
            res_valid_q  <= res_valid_d;
            err_q        <= err_d;
        end
    end

    assign word_out     = word_q;
    assign word_valid   = word_valid_q;
    assign result_out   = res_q;
    assign result_valid = res_valid_q;
    assign err_illegal  = err_q;
endmodule
